// File: rtl/ld_cell_proc.sv
// ld_cell_proc: conditions the left/right load-cell readings for balance_cntrl and
// steer_en_SM. It produces the signed cell difference, the rider-weight and
// difference comparator flags, the steer timer and a debounced low-battery flag.
// Build option: define LD_CELL_AVG_EN to run each cell through a 4-tap moving
// average. When it is undefined, each cell sample is registered as-is.
module ld_cell_proc #(
  parameter logic        fast_sim     = 1'b0,
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [7:0]  WT_HYST      = 8'h40,
  parameter logic [11:0] BATT_THRES   = 12'h800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic [11:0] batt,
  input  logic        clr_tmr,
  output logic [11:0] ld_cell_diff,
  output logic        sum_gt_min,
  output logic        sum_lt_min,
  output logic        diff_gt_eigth,
  output logic        diff_gt_15_16,
  output logic        tmr_full,
  output logic        batt_low
);

  localparam int TMR_W = (fast_sim == 1'b1) ? 15 : 26;
  localparam logic [TMR_W-1:0] TMR_MAX = {TMR_W{1'b1}};
  localparam logic [12:0] SUM_HI = {1'b0, MIN_RIDER_WT} + {5'b0_0000, WT_HYST};
  localparam logic [12:0] SUM_LO = {1'b0, MIN_RIDER_WT} - {5'b0_0000, WT_HYST};

  // Stage 1: per-channel conditioned values
  logic [11:0] lft_avg_d, lft_avg_q, rght_avg_d, rght_avg_q;
  logic        vld1_q;

  // Stage 2: registered outputs
  logic [11:0] diff_d, diff_q;
  logic        gt_d, gt_q, lt_d, lt_q, e8_d, e8_q, e15_d, e15_q;
  logic [12:0] sum_s, diff_s, absd_s, e15_thr_s;

  // Steer timer and battery debounce
  logic [TMR_W-1:0] tmr_d, tmr_q;
  logic             tmr_full_d, tmr_full_q;
  logic [1:0]       low_cnt_d, low_cnt_q, high_cnt_d, high_cnt_q;
  logic             batt_low_d, batt_low_q;

`ifdef LD_CELL_AVG_EN
  logic [11:0] lft_h0_d, lft_h0_q, lft_h1_d, lft_h1_q, lft_h2_d, lft_h2_q;
  logic [11:0] rght_h0_d, rght_h0_q, rght_h1_d, rght_h1_q, rght_h2_d, rght_h2_q;
  logic [13:0] lft_acc_s, rght_acc_s;

  // Moving average: sum of the new sample and three previous ones, history shifts on ld_vld
  always_comb begin
    lft_acc_s  = {2'b00, lft_ld} + {2'b00, lft_h0_q} + {2'b00, lft_h1_q} + {2'b00, lft_h2_q};
    rght_acc_s = {2'b00, rght_ld} + {2'b00, rght_h0_q} + {2'b00, rght_h1_q} + {2'b00, rght_h2_q};
    lft_h0_d   = lft_h0_q;
    lft_h1_d   = lft_h1_q;
    lft_h2_d   = lft_h2_q;
    rght_h0_d  = rght_h0_q;
    rght_h1_d  = rght_h1_q;
    rght_h2_d  = rght_h2_q;
    lft_avg_d  = lft_avg_q;
    rght_avg_d = rght_avg_q;
    if (ld_vld) begin
      lft_h0_d   = lft_ld;
      lft_h1_d   = lft_h0_q;
      lft_h2_d   = lft_h1_q;
      rght_h0_d  = rght_ld;
      rght_h1_d  = rght_h0_q;
      rght_h2_d  = rght_h1_q;
      lft_avg_d  = lft_acc_s[13:2];
      rght_avg_d = rght_acc_s[13:2];
    end else begin
      lft_avg_d  = lft_avg_q;
      rght_avg_d = rght_avg_q;
    end
  end

  // History registers; reset empties the filter so it re-primes from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_h0_q  <= 12'h000;
      lft_h1_q  <= 12'h000;
      lft_h2_q  <= 12'h000;
      rght_h0_q <= 12'h000;
      rght_h1_q <= 12'h000;
      rght_h2_q <= 12'h000;
    end else begin
      lft_h0_q  <= lft_h0_d;
      lft_h1_q  <= lft_h1_d;
      lft_h2_q  <= lft_h2_d;
      rght_h0_q <= rght_h0_d;
      rght_h1_q <= rght_h1_d;
      rght_h2_q <= rght_h2_d;
    end
  end
`else
  // Unfiltered: capture the raw samples on each strobe
  always_comb begin
    if (ld_vld) begin
      lft_avg_d  = lft_ld;
      rght_avg_d = rght_ld;
    end else begin
      lft_avg_d  = lft_avg_q;
      rght_avg_d = rght_avg_q;
    end
  end
`endif

  // Stage 2 arithmetic: sum, signed difference, magnitude and comparator flags
  always_comb begin
    sum_s     = {1'b0, lft_avg_q} + {1'b0, rght_avg_q};
    diff_s    = {1'b0, lft_avg_q} - {1'b0, rght_avg_q};
    absd_s    = diff_s[12] ? (13'd0 - diff_s) : diff_s;
    e15_thr_s = sum_s - (sum_s >> 4);
    diff_d    = diff_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    e8_d      = e8_q;
    e15_d     = e15_q;
    if (vld1_q) begin
      // The 13-bit diff fits in 12 signed bits exactly when bit 11 matches the sign.
      if (diff_s[12] == diff_s[11]) begin
        diff_d = diff_s[11:0];
      end else if (diff_s[12]) begin
        diff_d = 12'h800;
      end else begin
        diff_d = 12'h7FF;
      end
      gt_d  = (sum_s > SUM_HI);
      lt_d  = (sum_s < SUM_LO);
      e8_d  = (absd_s > (sum_s >> 3));
      e15_d = (absd_s > e15_thr_s);
    end else begin
      diff_d = diff_q;
    end
  end

  // Steer timer: clear wins, otherwise count up and stick at all-ones
  always_comb begin
    if (clr_tmr) begin
      tmr_d = {TMR_W{1'b0}};
    end else if (tmr_q == TMR_MAX) begin
      tmr_d = tmr_q;
    end else begin
      tmr_d = tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
    end
    tmr_full_d = (tmr_d == TMR_MAX);
  end

  // Battery debounce: four consecutive same-side strobes flip batt_low
  always_comb begin
    low_cnt_d  = low_cnt_q;
    high_cnt_d = high_cnt_q;
    batt_low_d = batt_low_q;
    if (ld_vld) begin
      if (batt < BATT_THRES) begin
        high_cnt_d = 2'd0;
        if (low_cnt_q == 2'd3) begin
          batt_low_d = 1'b1;
        end else begin
          low_cnt_d = low_cnt_q + 2'd1;
        end
      end else begin
        low_cnt_d = 2'd0;
        if (high_cnt_q == 2'd3) begin
          batt_low_d = 1'b0;
        end else begin
          high_cnt_d = high_cnt_q + 2'd1;
        end
      end
    end else begin
      batt_low_d = batt_low_q;
    end
  end

  // Pipeline, timer and debounce state
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_avg_q  <= 12'h000;
      rght_avg_q <= 12'h000;
      vld1_q     <= 1'b0;
      diff_q     <= 12'h000;
      gt_q       <= 1'b0;
      lt_q       <= 1'b0;
      e8_q       <= 1'b0;
      e15_q      <= 1'b0;
      tmr_q      <= {TMR_W{1'b0}};
      tmr_full_q <= 1'b0;
      low_cnt_q  <= 2'd0;
      high_cnt_q <= 2'd0;
      batt_low_q <= 1'b0;
    end else begin
      lft_avg_q  <= lft_avg_d;
      rght_avg_q <= rght_avg_d;
      vld1_q     <= ld_vld;
      diff_q     <= diff_d;
      gt_q       <= gt_d;
      lt_q       <= lt_d;
      e8_q       <= e8_d;
      e15_q      <= e15_d;
      tmr_q      <= tmr_d;
      tmr_full_q <= tmr_full_d;
      low_cnt_q  <= low_cnt_d;
      high_cnt_q <= high_cnt_d;
      batt_low_q <= batt_low_d;
    end
  end

  assign ld_cell_diff  = diff_q;
  assign sum_gt_min    = gt_q;
  assign sum_lt_min    = lt_q;
  assign diff_gt_eigth = e8_q;
  assign diff_gt_15_16 = e15_q;
  assign tmr_full      = tmr_full_q;
  assign batt_low      = batt_low_q;

endmodule
